// File: rtl/eth_link_monitor.sv
// Per-port Ethernet link qualifier and statistics block.
// A per-port FSM debounces the MAC ready flag into a qualified link-up. Saturating
// counters track link flaps and RX/TX frames and errors seen on the AXIS taps.
// Status and counters are exposed on an APB slave that always inserts one wait state.
module eth_link_monitor #(
    parameter int          NUM_PORTS    = 4,
    parameter int          DEBOUNCE_CYC = 1024,
    parameter int          CNT_WIDTH    = 32,
    parameter logic [31:0] APB_BASE     = 32'h0
) (
    input  logic                 eth_clk,
    input  logic                 eth_rst,
    input  logic [NUM_PORTS-1:0] i_mac_rdy,
    input  logic [NUM_PORTS-1:0] i_rx_tvalid,
    input  logic [NUM_PORTS-1:0] i_rx_tlast,
    input  logic [NUM_PORTS-1:0] i_rx_tuser,
    input  logic [NUM_PORTS-1:0] i_tx_tvalid,
    input  logic [NUM_PORTS-1:0] i_tx_tready,
    input  logic [NUM_PORTS-1:0] i_tx_tlast,
    output logic [NUM_PORTS-1:0] o_eth_rdy,
    output logic [NUM_PORTS-1:0] o_link_chg,
    input  logic                 i_eth_apb_psel,
    input  logic                 i_eth_apb_penable,
    input  logic [31:0]          i_eth_apb_paddr,
    input  logic [31:0]          i_eth_apb_pwdata,
    input  logic                 i_eth_apb_pwrite,
    output logic                 o_eth_apb_pready,
    output logic [31:0]          o_eth_apb_prdata,
    output logic                 o_eth_apb_pserr
);

    localparam int                 TMR_W       = $clog2(DEBOUNCE_CYC);
    localparam logic [TMR_W-1:0]   TMR_LAST    = TMR_W'(DEBOUNCE_CYC - 1);
    localparam logic [3:0]         NUM_PORTS_L = 4'(NUM_PORTS);

    typedef enum logic [1:0] {
        ST_DOWN = 2'd0,
        ST_QUAL = 2'd1,
        ST_UP   = 2'd2
    } link_state_t;

    // ------------------------------------------------------------------
    // APB address decode
    // ------------------------------------------------------------------
    logic        apb_start;
    logic        base_hit;
    logic [2:0]  port_idx;
    logic [4:0]  reg_off;
    logic        port_ok;
    logic        off_ok;
    logic        is_ctrl;
    logic        acc_err;
    logic        ctrl_wr;
    logic [31:0] rd_data;
    logic [31:0] port_rd_data [NUM_PORTS];
    logic        pready_reg;
    logic        pserr_reg;
    logic [31:0] prdata_reg;
    logic        unused_pwdata;

    // An access is served in the first cycle psel&penable is seen; pready_reg blocks
    // the completion cycle from being mistaken for a new access.
    assign apb_start = i_eth_apb_psel & i_eth_apb_penable & ~pready_reg;
    assign base_hit  = (i_eth_apb_paddr[31:8] == APB_BASE[31:8]);
    assign port_idx  = i_eth_apb_paddr[7:5];
    assign reg_off   = i_eth_apb_paddr[4:0];
    assign port_ok   = ({1'b0, port_idx} < NUM_PORTS_L);
    assign off_ok    = (i_eth_apb_paddr[1:0] == 2'b00) && (reg_off <= 5'h14);
    assign is_ctrl   = (reg_off == 5'h14);
    // CTRL is the only writable register and it is write-only.
    assign acc_err   = ~base_hit | ~port_ok | ~off_ok
                     | (i_eth_apb_pwrite & ~is_ctrl)
                     | (~i_eth_apb_pwrite & is_ctrl);
    assign ctrl_wr   = apb_start & i_eth_apb_pwrite & ~acc_err & i_eth_apb_pwdata[0];
    assign unused_pwdata = ^i_eth_apb_pwdata[31:1];

    // Select the addressed port's register word
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_idx == 3'(p)) begin
                rd_data = port_rd_data[p];
            end
        end
    end

    // APB response registers: one-cycle pready, data only on good reads
    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            pready_reg <= 1'b0;
            pserr_reg  <= 1'b0;
            prdata_reg <= '0;
        end else begin
            pready_reg <= apb_start;
            pserr_reg  <= apb_start & acc_err;
            prdata_reg <= (apb_start & ~i_eth_apb_pwrite & ~acc_err) ? rd_data : 32'h0;
        end
    end

    assign o_eth_apb_pready = pready_reg;
    assign o_eth_apb_pserr  = pserr_reg;
    assign o_eth_apb_prdata = prdata_reg;

    // ------------------------------------------------------------------
    // Per-port link qualifier and counters
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            link_state_t          state_reg, state_next;
            logic [TMR_W-1:0]     timer_reg, timer_next;
            logic                 eth_rdy_reg;
            logic                 link_chg_reg;
            logic                 clr;
            logic                 flap_inc;
            logic                 rx_frm_inc;
            logic                 rx_err_inc;
            logic                 tx_frm_inc;
            logic [CNT_WIDTH-1:0] flap_cnt_reg;
            logic [CNT_WIDTH-1:0] rx_frm_reg;
            logic [CNT_WIDTH-1:0] rx_err_reg;
            logic [CNT_WIDTH-1:0] tx_frm_reg;

            assign clr        = ctrl_wr & (port_idx == 3'(gi));
            assign flap_inc   = (state_reg == ST_UP) & (state_next == ST_DOWN);
            assign rx_frm_inc = i_rx_tvalid[gi] & i_rx_tlast[gi];
            assign rx_err_inc = i_rx_tvalid[gi] & i_rx_tlast[gi] & i_rx_tuser[gi];
            assign tx_frm_inc = i_tx_tvalid[gi] & i_tx_tready[gi] & i_tx_tlast[gi];

            // Debounce FSM: qualify on a continuous high run, drop instantly on loss
            always_comb begin
                state_next = state_reg;
                timer_next = timer_reg;
                case (state_reg)
                    ST_DOWN: begin
                        if (i_mac_rdy[gi]) begin
                            state_next = ST_QUAL;
                            timer_next = '0;
                        end
                    end
                    ST_QUAL: begin
                        if (!i_mac_rdy[gi]) begin
                            state_next = ST_DOWN;
                            timer_next = '0;
                        end else if (timer_reg == TMR_LAST) begin
                            state_next = ST_UP;
                            timer_next = '0;
                        end else begin
                            timer_next = timer_reg + TMR_W'(1);
                        end
                    end
                    ST_UP: begin
                        if (!i_mac_rdy[gi]) begin
                            state_next = ST_DOWN;
                        end
                    end
                    default: begin
                        state_next = ST_DOWN;
                        timer_next = '0;
                    end
                endcase
            end

            // State, timer and registered link outputs (change in the same cycle)
            always_ff @(posedge eth_clk) begin
                if (eth_rst) begin
                    state_reg    <= ST_DOWN;
                    timer_reg    <= '0;
                    eth_rdy_reg  <= 1'b0;
                    link_chg_reg <= 1'b0;
                end else begin
                    state_reg    <= state_next;
                    timer_reg    <= timer_next;
                    eth_rdy_reg  <= (state_next == ST_UP);
                    link_chg_reg <= (state_next == ST_UP) != (state_reg == ST_UP);
                end
            end

            // Saturating statistics; a clear beats a same-cycle increment
            always_ff @(posedge eth_clk) begin
                if (eth_rst || clr) begin
                    flap_cnt_reg <= '0;
                    rx_frm_reg   <= '0;
                    rx_err_reg   <= '0;
                    tx_frm_reg   <= '0;
                end else begin
                    if (flap_inc && (flap_cnt_reg != '1)) flap_cnt_reg <= flap_cnt_reg + CNT_WIDTH'(1);
                    if (rx_frm_inc && (rx_frm_reg != '1)) rx_frm_reg   <= rx_frm_reg + CNT_WIDTH'(1);
                    if (rx_err_inc && (rx_err_reg != '1)) rx_err_reg   <= rx_err_reg + CNT_WIDTH'(1);
                    if (tx_frm_inc && (tx_frm_reg != '1)) tx_frm_reg   <= tx_frm_reg + CNT_WIDTH'(1);
                end
            end

            assign o_eth_rdy[gi]  = eth_rdy_reg;
            assign o_link_chg[gi] = link_chg_reg;

            assign port_rd_data[gi] =
                (reg_off == 5'h00) ? {30'b0, i_mac_rdy[gi], eth_rdy_reg} :
                (reg_off == 5'h04) ? 32'(flap_cnt_reg) :
                (reg_off == 5'h08) ? 32'(rx_frm_reg)   :
                (reg_off == 5'h0C) ? 32'(rx_err_reg)   :
                (reg_off == 5'h10) ? 32'(tx_frm_reg)   : 32'h0;
        end
    endgenerate

endmodule
